lidar_cmd_sequencer: RTL and testbench

- Sequences TF-LC02 command frames onto the single byte-wide UART transmitter.
- Arbitrates between two command sources: a host/config request port and an internal periodic measurement trigger.
- Each frame is emitted one byte at a time using the transmitter's ready/start/done handshake.
- Sits between the top-level LiDAR controller logic and the UART transmit block.

---
 rtl/lidar_pkg.sv | 44 ++++
 rtl/lidar_tick_timer.sv | 43 ++++
 rtl/lidar_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_lidar_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lidar_pkg.sv
`default_nettype none
// ============================================================================
// lidar_pkg : shared frame constants, command codes and sequencer state type
// Revision  : 1.0
// ============================================================================
package lidar_pkg;

    localparam logic [7:0] HDR0      = 8'h55;
    localparam logic [7:0] HDR1      = 8'hAA;
    localparam logic [7:0] TAIL      = 8'hFA;
    localparam logic [7:0] LEN_BYTE  = 8'h00;
    localparam int         FRAME_LEN = 5;

    localparam logic [7:0] CMD_MEAS  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'h60;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Byte at position idx of a frame carrying command byte cmd.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [7:0] cmd,
        input logic [7:0] hdr0,
        input logic [7:0] hdr1,
        input logic [7:0] tail
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr0;
            3'd1:    b = hdr1;
            3'd2:    b = cmd;
            3'd3:    b = LEN_BYTE;
            default: b = tail;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lidar_tick_timer.sv
`default_nettype none
// ============================================================================
// lidar_tick_timer : periodic measurement counter with a single pending flag
// Revision         : 1.0
// ============================================================================
module lidar_tick_timer #(
    parameter int PERIOD_CYCLES = 5_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_fEn,
    input  logic i_fClr,
    output logic o_fPend
);

    localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

    logic [CW-1:0] count;
    logic          pend;
    logic          wrap;

    assign wrap    = (count == CW'(PERIOD_CYCLES - 1));
    assign o_fPend = pend;

    // A fresh tick wins over a same-cycle clear so no period is ever lost.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            count <= '0;
            pend  <= 1'b0;
        end else if (!i_fEn) begin
            count <= '0;
            pend  <= 1'b0;
        end else begin
            count <= wrap ? '0 : count + CW'(1);
            if (wrap)
                pend <= 1'b1;
            else if (i_fClr)
                pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lidar_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// lidar_cmd_sequencer : arbitrates host/auto commands and streams 5-byte
//                       frames onto a byte-wide UART transmitter
// Revision            : 1.0
// ============================================================================
module lidar_cmd_sequencer #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         PERIOD_CYCLES = CLK_FREQ / 10,
    parameter logic [7:0] MEAS_CMD      = lidar_pkg::CMD_MEAS,
    parameter logic [7:0] HDR0          = lidar_pkg::HDR0,
    parameter logic [7:0] HDR1          = lidar_pkg::HDR1,
    parameter logic [7:0] TAIL          = lidar_pkg::TAIL
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_fReq,
    input  logic [7:0] i_Cmd,
    input  logic       i_fAutoEn,
    output logic       o_fReady,
    output logic       o_fBusy,
    output logic       o_fCmdDone,
    output logic       o_fAutoSrc,
    output logic       o_fTx,
    output logic [7:0] o_TxData,
    input  logic       i_fTxReady,
    input  logic       i_fTxDone
);

    import lidar_pkg::*;

    seq_state_t state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] cmd_reg, cmd_nx;
    logic       auto_src, auto_src_nx;
    logic [7:0] data_reg;
    logic [7:0] cur_byte;
    logic       pend;
    logic       clr_pend;
    logic       fire;

    lidar_tick_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_tick_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_fEn   (i_fAutoEn),
        .i_fClr  (clr_pend),
        .o_fPend (pend)
    );

    assign cur_byte = frame_byte(idx, cmd_reg, HDR0, HDR1, TAIL);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            cmd_reg  <= 8'h00;
            auto_src <= 1'b0;
            data_reg <= 8'h00;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            cmd_reg  <= cmd_nx;
            auto_src <= auto_src_nx;
            if (fire)
                data_reg <= cur_byte;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cmd_nx      = cmd_reg;
        auto_src_nx = auto_src;
        clr_pend    = 1'b0;
        fire        = 1'b0;
        case (state)
            IDLE: begin
                // Host wins; a pending auto tick survives and runs next.
                if (i_fReq) begin
                    cmd_nx      = i_Cmd;
                    auto_src_nx = 1'b0;
                    state_nx    = SEND;
                end else if (pend) begin
                    cmd_nx      = MEAS_CMD;
                    auto_src_nx = 1'b1;
                    clr_pend    = 1'b1;
                    state_nx    = SEND;
                end
            end
            SEND: begin
                if (i_fTxReady) begin
                    fire     = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (i_fTxDone) begin
                    if (idx == 3'(FRAME_LEN - 1)) begin
                        idx_nx   = 3'd0;
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = SEND;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The start pulse is combinational so a released stall fires the same cycle.
    assign o_fTx      = fire;
    assign o_TxData   = fire ? cur_byte : data_reg;
    assign o_fCmdDone = (state == DONE);
    assign o_fBusy    = (state != IDLE);
    assign o_fReady   = (state == IDLE) && !pend;
    assign o_fAutoSrc = auto_src;

endmodule
`default_nettype wire

// File: tb/tb_lidar_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lidar_cmd_sequencer : scoreboard bench with a behavioural UART model
// Revision               : 1.0
// ============================================================================
module tb_lidar_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [7:0] cmd;
    logic       auto_en;
    logic       tx_ready;
    logic       tx_done;
    logic       ready, busy, cmd_done, auto_src, tx_fire;
    logic [7:0] tx_data;

    int checks   = 0;
    int failures = 0;
    int fires    = 0;
    int dones    = 0;
    int cyc      = 0;
    int last_fire_cyc = 0;
    int last_done_cyc = 0;
    bit stall    = 1'b0;

    logic [7:0] exp_q[$];
    logic       src_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lidar_cmd_sequencer #(
        .PERIOD_CYCLES (100)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_fReq     (req),
        .i_Cmd      (cmd),
        .i_fAutoEn  (auto_en),
        .o_fReady   (ready),
        .o_fBusy    (busy),
        .o_fCmdDone (cmd_done),
        .o_fAutoSrc (auto_src),
        .o_fTx      (tx_fire),
        .o_TxData   (tx_data),
        .i_fTxReady (tx_ready),
        .i_fTxDone  (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic src);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(c);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFA);
        src_q.push_back(src);
    endtask

    // UART model: busy for a few cycles after each start pulse, then one done pulse.
    initial begin : uart_model
        int  cnt;
        logic seen;
        cnt      = 0;
        tx_ready = 1'b1;
        tx_done  = 1'b0;
        forever begin
            @(negedge clk);
            seen = tx_fire;
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (seen) begin
                cnt = 5;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
            tx_ready = (cnt == 0) && !stall;
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (tx_fire) begin
                fires++;
                last_fire_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got %0h, expected no transmission", tx_data);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (cmd_done) begin
                dones++;
                last_done_cyc = cyc;
                if (src_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    check("auto_src", {31'h0, auto_src}, {31'h0, src_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_fires(input int target, input int budget);
        int n;
        n = 0;
        while (fires < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (fires < target) begin
            checks++;
            failures++;
            $display("FAIL wait_fires_timeout: got %0d, expected %0d", fires, target);
        end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (dones < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (dones < target) begin
            checks++;
            failures++;
            $display("FAIL wait_dones_timeout: got %0d, expected %0d", dones, target);
        end
    endtask

    task automatic send_req(input logic [7:0] c);
        @(posedge clk);
        #1;
        req = 1'b1;
        cmd = c;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},      {31'h0, tx_fire},  32'h0);
        check({tag, "_data"},    {24'h0, tx_data},  32'h0);
        check({tag, "_done"},    {31'h0, cmd_done}, 32'h0);
        check({tag, "_busy"},    {31'h0, busy},     32'h0);
        check({tag, "_autosrc"}, {31'h0, auto_src}, 32'h0);
        check({tag, "_ready"},   {31'h0, ready},    32'h1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int f0, d0, c0, done_at;
        rst_n   = 1'b0;
        req     = 1'b0;
        cmd     = 8'h00;
        auto_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Host frame, first start one cycle after acceptance
        f0 = fires; d0 = dones;
        push_frame(8'h60, 1'b0);
        send_req(8'h60);
        @(negedge clk);
        check("first_tx_latency", {31'h0, tx_fire}, 32'h1);
        check("busy_in_frame", {31'h0, busy}, 32'h1);
        wait_dones(d0 + 1, 200);
        repeat (10) @(posedge clk);
        check("host_fire_count", fires - f0, 32'd5);
        check("host_done_count", dones - d0, 32'd1);

        // Periodic auto frames
        f0 = fires; d0 = dones;
        push_frame(8'h01, 1'b1);
        push_frame(8'h01, 1'b1);
        @(posedge clk);
        #1;
        auto_en = 1'b1;
        c0 = cyc;
        wait_fires(f0 + 1, 300);
        check("auto_first_start", last_fire_cyc - c0, 32'd101);
        wait_fires(f0 + 6, 300);
        check("auto_second_start", last_fire_cyc - c0, 32'd201);
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        wait_dones(d0 + 2, 200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_after_auto", {31'h0, ready}, 32'h1);

        // Tick and host request in the same idle cycle
        f0 = fires; d0 = dones;
        push_frame(8'h60, 1'b0);
        push_frame(8'h01, 1'b1);
        @(posedge clk);
        #1;
        auto_en = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        req = 1'b1;
        cmd = 8'h60;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_dones(d0 + 1, 200);
        done_at = last_done_cyc;
        wait_fires(f0 + 6, 50);
        check("auto_follow_gap", last_fire_cyc - done_at, 32'd2);
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        wait_dones(d0 + 2, 200);
        repeat (5) @(posedge clk);

        // Requests while busy are dropped
        f0 = fires; d0 = dones;
        push_frame(8'h33, 1'b0);
        send_req(8'h33);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk);
            #1;
            req = 1'b1;
            cmd = 8'h77;
            @(posedge clk);
            #1;
            req = 1'b0;
        end
        wait_dones(d0 + 1, 200);
        repeat (20) @(posedge clk);
        check("busy_req_fires", fires - f0, 32'd5);
        check("busy_req_dones", dones - d0, 32'd1);

        // Long stall in SEND with three ticks coalescing into one auto frame
        f0 = fires; d0 = dones;
        push_frame(8'h42, 1'b0);
        push_frame(8'h01, 1'b1);
        @(posedge clk);
        #1;
        stall   = 1'b1;
        auto_en = 1'b1;
        req     = 1'b1;
        cmd     = 8'h42;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("stall_no_fire", fires - f0, 32'd0);
        check("stall_busy", {31'h0, busy}, 32'h1);
        repeat (270) @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_fire", {31'h0, tx_fire}, 32'h1);
        wait_fires(f0 + 6, 200);
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        wait_dones(d0 + 2, 200);
        repeat (250) @(posedge clk);
        check("coalesce_fires", fires - f0, 32'd10);
        check("coalesce_dones", dones - d0, 32'd2);

        // Reset in the middle of a frame
        f0 = fires;
        push_frame(8'h60, 1'b0);
        send_req(8'h60);
        wait_fires(f0 + 3, 100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        src_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        d0 = dones;
        push_frame(8'h11, 1'b0);
        send_req(8'h11);
        wait_dones(d0 + 1, 200);
        repeat (5) @(posedge clk);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
